// File: rtl/hs_cdc_pkg.sv
// Shared definitions for the toggle-based CDC handshake (sender and receiver).
//  hs_state_t      : receiver FSM state, IDLE (no word held) / HOLD (word on out_data)
//  SYNC_STAGES_MIN : smallest legal synchronizer depth
package hs_cdc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } hs_state_t;

    localparam int SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/bit_sync.sv
// N-stage single-bit synchronizer with synchronous active-high reset.
//  clk : destination clock
//  rst : synchronous active-high reset, clears every stage
//  d   : asynchronous input bit
//  q   : synchronized output (last stage)
module bit_sync
    import hs_cdc_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    if (STAGES < SYNC_STAGES_MIN) begin : g_bad_stages
        $error("bit_sync: STAGES must be >= %0d", SYNC_STAGES_MIN);
    end

    // sync[0] is the metastability-catching flop; sync[STAGES-1] is safe to use.
    logic [STAGES-1:0] sync;

    always_ff @(posedge clk) begin
        if (rst) sync <= '0;
        else     sync <= {sync[STAGES-2:0], d};
    end

    assign q = sync[STAGES-1];

endmodule

// File: rtl/hs_toggle_rx.sv
// Destination-side receiver of the toggle CDC handshake.
// Each level change on req_tgl delivers one req_data word on a valid/ready
// interface; ack_tgl flips once the consumer takes the word.
//  clk       : destination clock
//  rst       : synchronous active-high reset
//  req_tgl   : async request toggle from sender
//  req_data  : async data, stable from toggle until ack (false-path / max-delay)
//  out_valid : word available on out_data
//  out_data  : captured word
//  out_ready : consumer accept
//  ack_tgl   : ack toggle back to sender
//  xfer_cnt  : accepted word count, wraps
//  proto_err : sticky, request edge arrived while a word was held
module hs_toggle_rx
    import hs_cdc_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_tgl,
    input  logic [DATA_W-1:0] req_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              ack_tgl,
    output logic [CNT_W-1:0]  xfer_cnt,
    output logic              proto_err
);

    if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_sync
        $error("hs_toggle_rx: SYNC_STAGES must be >= %0d", SYNC_STAGES_MIN);
    end

    hs_state_t state, state_nxt;
    logic      req_sync;
    logic      prev_sync;
    logic      req_edge;
    logic      capture;
    logic      accept;
    logic      err_set;

    bit_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
        .clk (clk),
        .rst (rst),
        .d   (req_tgl),
        .q   (req_sync)
    );

    always_ff @(posedge clk) begin
        if (rst) prev_sync <= 1'b0;
        else     prev_sync <= req_sync;
    end

    assign req_edge = req_sync ^ prev_sync;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_edge)              state_nxt = HOLD;
            HOLD: if (out_valid && out_ready) state_nxt = IDLE;
            default:                          state_nxt = IDLE;
        endcase
    end

    // FSM: outputs / datapath strobes. An edge seen while HOLD is dropped
    // (never captured) and only raises the error flag, even if the held word
    // is being accepted in that same cycle.
    always_comb begin
        out_valid = (state == HOLD);
        capture   = (state == IDLE) && req_edge;
        accept    = (state == HOLD) && out_ready;
        err_set   = (state == HOLD) && req_edge;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            ack_tgl   <= 1'b0;
            xfer_cnt  <= '0;
            proto_err <= 1'b0;
        end else begin
            // req_data has been stable for >= SYNC_STAGES clocks by the edge cycle
            if (capture) out_data <= req_data;
            if (accept) begin
                ack_tgl  <= ~ack_tgl;
                xfer_cnt <= xfer_cnt + CNT_W'(1);
            end
            if (err_set) proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hs_toggle_rx.sv
module tb_hs_toggle_rx;

    localparam int DATA_W = 8;
    localparam int SYNC   = 2;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_tgl = 1'b1;
    logic [DATA_W-1:0] req_data = '0;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready = 1'b0;
    logic              ack_tgl;
    logic [CNT_W-1:0]  xfer_cnt;
    logic              proto_err;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic              exp_ack = 1'b0;
    logic [CNT_W-1:0]  exp_cnt = '0;
    logic              stream_done;

    hs_toggle_rx #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_tgl   (req_tgl),
        .req_data  (req_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .ack_tgl   (ack_tgl),
        .xfer_cnt  (xfer_cnt),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // one clock, then settle just past the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        exp_q.delete();
        rst      = 1'b1;
        req_tgl  = 1'b0;
        req_data = '0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!out_valid && n < 40) begin
            cyc();
            n++;
        end
        chk(name, {31'b0, out_valid}, 32'd1);
    endtask

    task automatic wait_ack_flip(input logic old, input string name);
        int n = 0;
        while (ack_tgl === old && n < 200) begin
            cyc();
            n++;
        end
        chk(name, {31'b0, ack_tgl}, {31'b0, ~old});
    endtask

    // model sender: toggle, then hold data until the ack is seen
    task automatic send(input logic [DATA_W-1:0] d);
        logic a;
        a = ack_tgl;
        exp_q.push_back(d);
        req_data = d;
        req_tgl  = ~req_tgl;
        wait_ack_flip(a, "send_ack");
        cyc();
    endtask

    // scoreboard monitor: pops one expected word per handshake and tracks ack/count
    always @(negedge clk) begin
        if (rst) begin
            exp_ack = 1'b0;
            exp_cnt = '0;
        end else begin
            chk("mon_ack", {31'b0, ack_tgl}, {31'b0, exp_ack});
            chk("mon_cnt", 32'(xfer_cnt), 32'(exp_cnt));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("mon_unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    chk("mon_data", 32'(out_data), 32'(exp_q.pop_front()));
                end
                exp_ack = ~exp_ack;
                exp_cnt = exp_cnt + 1'b1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        stream_done = 1'b0;

        // reset with req_tgl already high
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_valid", {31'b0, out_valid}, 32'd0);
            chk("rst_data",  32'(out_data), 32'd0);
            chk("rst_ack",   {31'b0, ack_tgl}, 32'd0);
            chk("rst_cnt",   32'(xfer_cnt), 32'd0);
            chk("rst_err",   {31'b0, proto_err}, 32'd0);
        end
        req_data = 8'h3C;
        exp_q.push_back(8'h3C);
        out_ready = 1'b1;
        rst = 1'b0;
        wait_ack_flip(1'b0, "post_rst_ack");
        for (int i = 0; i < 4; i++) cyc();
        chk("post_rst_single", {31'b0, out_valid}, 32'd0);
        chk("post_rst_cnt", 32'(xfer_cnt), 32'd1);

        // single transfer latency
        do_reset();
        out_ready = 1'b1;
        req_data  = 8'hA5;
        exp_q.push_back(8'hA5);
        req_tgl   = 1'b1;
        cyc();
        chk("lat_k0_valid", {31'b0, out_valid}, 32'd0);
        cyc();
        chk("lat_k1_valid", {31'b0, out_valid}, 32'd0);
        cyc();
        chk("lat_k2_valid", {31'b0, out_valid}, 32'd1);
        chk("lat_k2_data",  32'(out_data), 32'hA5);
        chk("lat_k2_ack",   {31'b0, ack_tgl}, 32'd0);
        cyc();
        chk("lat_k3_valid", {31'b0, out_valid}, 32'd0);
        chk("lat_k3_ack",   {31'b0, ack_tgl}, 32'd1);
        chk("lat_k3_cnt",   32'(xfer_cnt), 32'd1);

        // backpressure
        out_ready = 1'b0;
        exp_q.push_back(8'hA5);
        req_tgl = 1'b0;
        wait_valid("bp_valid");
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_hold_data",  32'(out_data), 32'hA5);
            chk("bp_hold_ack",   {31'b0, ack_tgl}, 32'd1);
        end
        out_ready = 1'b1;
        cyc();
        chk("bp_rel_valid", {31'b0, out_valid}, 32'd0);
        chk("bp_rel_ack",   {31'b0, ack_tgl}, 32'd0);
        chk("bp_rel_cnt",   32'(xfer_cnt), 32'd2);

        // protocol violation: second toggle while holding
        out_ready = 1'b0;
        req_data  = 8'h11;
        exp_q.push_back(8'h11);
        req_tgl   = 1'b1;
        wait_valid("pe_valid");
        chk("pe_err_before", {31'b0, proto_err}, 32'd0);
        req_data = 8'h22;
        req_tgl  = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        chk("pe_err",   {31'b0, proto_err}, 32'd1);
        chk("pe_data",  32'(out_data), 32'h11);
        chk("pe_valid_held", {31'b0, out_valid}, 32'd1);
        out_ready = 1'b1;
        cyc();
        chk("pe_cnt", 32'(xfer_cnt), 32'd3);
        for (int i = 0; i < 5; i++) cyc();
        chk("pe_dropped", {31'b0, out_valid}, 32'd0);
        chk("pe_cnt_once", 32'(xfer_cnt), 32'd3);
        chk("pe_sticky", {31'b0, proto_err}, 32'd1);

        // reset while holding a word
        out_ready = 1'b0;
        req_data  = 8'h77;
        exp_q.push_back(8'h77);
        req_tgl   = 1'b1;
        wait_valid("rh_valid");
        do_reset();
        chk("rh_valid", {31'b0, out_valid}, 32'd0);
        chk("rh_ack",   {31'b0, ack_tgl}, 32'd0);
        chk("rh_err",   {31'b0, proto_err}, 32'd0);
        chk("rh_cnt",   32'(xfer_cnt), 32'd0);
        out_ready = 1'b1;
        send(8'h9C);
        chk("rh_fresh_cnt", 32'(xfer_cnt), 32'd1);

        // stream of 300 words with random ready, counter wraps at 256
        do_reset();
        fork
            begin
                for (int i = 0; i < 300; i++) send(8'(i * 7 + 3));
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    cyc();
                end
            end
        join
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        chk("st_cnt",   32'(xfer_cnt), 32'd44);
        chk("st_err",   {31'b0, proto_err}, 32'd0);
        chk("st_drain", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
